// File: rtl/credit_rx_buffer_if.sv
// Sender-side credit link plus downstream valid/ready stream of the credit receive buffer.
// The slave modport is the buffer; the master modport is whatever drives it.
interface credit_rx_buffer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 5
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                  in_vld;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  crd_rtn;
  logic                  out_vld;
  logic                  out_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CNT_W-1:0]      level;
  logic                  overflow;

  modport master (
    output in_vld, in_data, out_rdy,
    input  crd_rtn, out_vld, out_data, level, overflow
  );

  modport slave (
    input  in_vld, in_data, out_rdy,
    output crd_rtn, out_vld, out_data, level, overflow
  );
endinterface

// File: rtl/credit_rx_buffer.sv
// Receive end of a credit-based link: DEPTH-entry circular buffer feeding a valid/ready stream,
// returning one credit per freed entry after granting DEPTH initial credits out of reset.
module credit_rx_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  credit_rx_buffer_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d, init_cnt_q, init_cnt_d;
  logic                  crd_q, crd_d;
  logic                  out_vld_q, out_vld_d;
  logic                  ovf_q, ovf_d;
  logic                  push_c, pop_c;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Pointer advance with wrap for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    crd_d      = 1'b0;
    out_vld_d  = 1'b0;
    ovf_d      = ovf_q;

    pop_c  = out_vld_q && bus.out_rdy;
    push_c = bus.in_vld && ((count_q != CNT_W'(DEPTH)) || pop_c);

    // A word arriving with no free entry and no pop is dropped.
    if (bus.in_vld && !push_c) ovf_d = 1'b1;

    case (state_q)
      ST_INIT: begin
        crd_d = 1'b1;
        if (init_cnt_q == CNT_W'(DEPTH - 1)) state_d = ST_RUN;
        else init_cnt_d = init_cnt_q + CNT_W'(1);
      end
      ST_RUN:  crd_d = pop_c;
      default: state_d = ST_INIT;
    endcase

    if (push_c) tail_d = ptr_inc(tail_q);
    if (pop_c)  head_d = ptr_inc(head_q);

    if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
    else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);

    out_vld_d = (state_d == ST_RUN) && (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      crd_q      <= 1'b0;
      out_vld_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      crd_q      <= crd_d;
      out_vld_q  <= out_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset; only entries between head and tail are ever presented.
  always_ff @(posedge clk) begin
    if (push_c) mem[tail_q] <= bus.in_data;
  end

  assign bus.crd_rtn  = crd_q;
  assign bus.out_vld  = out_vld_q;
  assign bus.out_data = mem[head_q];
  assign bus.level    = count_q;
  assign bus.overflow = ovf_q;
endmodule

// File: doc/credit_rx_buffer.md
Name: credit_rx_buffer

Overview:
- Receive end of a credit-based link. The sender has no ready signal; it transmits only while it holds credits.
- The block stores incoming words in a DEPTH-entry circular buffer and presents them on a valid/ready stream downstream.
- It returns one credit per freed entry to the sender.
- After reset it grants the full DEPTH credits, so the paired sender comes out of reset with zero credits.

Parameters:
- DATA_WIDTH, 8, payload width in bits.
- DEPTH, 5, number of storage entries and initial credits; must be >= 2; need not be a power of two.
- CNT_W, $clog2(DEPTH+1), derived localparam; width of level and counters.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_vld  input  1  sender word valid; one word per cycle; no backpressure.
- in_data  input  DATA_WIDTH  sender word.
- crd_rtn  output  1  registered credit-return pulse, one credit per cycle high.
- out_vld  output  1  downstream valid.
- out_rdy  input  1  downstream ready.
- out_data  output  DATA_WIDTH  downstream word; equals mem[head].
- level  output  CNT_W  registered count of stored entries.
- overflow  output  1  sticky error: a word arrived with no free entry.

Behaviour:
- Reset (async, rst_n=0): the following are cleared immediately:
  - head, tail, count, init_cnt = 0
  - crd_rtn = 0, overflow = 0, level = 0, out_vld = 0
  - state = INIT
  - Storage contents are don't-care.
- State INIT:
  - crd_rtn is registered 1 on each of the first DEPTH rising edges after rst_n deasserts. init_cnt counts 0..DEPTH-1.
  - The edge where init_cnt==DEPTH-1 moves state to RUN.
  - out_vld is forced 0 throughout INIT.
  - Pushes are accepted normally during INIT.
- State RUN:
  - crd_rtn <= pop, giving exactly one cycle of latency from pop to credit.
  - RUN is never left except by reset.
- Push:
  - push = in_vld && (count<DEPTH || pop).
  - On push: mem[tail] <= in_data; tail advances, wrapping DEPTH-1 -> 0.
- Pop:
  - pop = out_vld && out_rdy; out_vld = (state==RUN) && (count!=0).
  - On pop: head advances with the same wrap rule.
  - out_data is combinational from mem[head] and must be stable while out_vld && !out_rdy.
- Latency: a word written at edge N is visible on out_vld/out_data after edge N (RUN only). There is no fall-through from in_data to out_data.
- count:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push+pop, including when full.
  - level = count.
- Overflow:
  - Condition: in_vld && count==DEPTH && !pop.
  - Effect: the word is dropped; tail and count are unchanged; overflow is set to 1 and held until reset.
  - This is a sender protocol violation. No credit is returned for a dropped word.
- Empty: out_vld=0; out_rdy is ignored.
- Credit conservation: after INIT, (sender credits) + count + (credits in flight) == DEPTH at all times, given a compliant sender.
- Reset mid-operation: all stored data is discarded and INIT replays DEPTH credits. The sender must be reset in the same domain event so that its credit counter returns to 0.

Test Plan:
- Release reset, DEPTH=5, in_vld=0 -> crd_rtn=1 on edges 1..5 after release, then 0; out_vld=0, level=0 throughout.
- Push 0x11..0x15 on consecutive cycles with out_rdy=0, then out_rdy=1 -> level=5, overflow=0.
  - out_data then shows 0x11..0x15 on consecutive cycles.
  - crd_rtn is high 5 cycles, each one cycle after the matching pop.
  - level returns to 0.
- Fill to 5, then in_vld=1 with in_data=0x16 and out_rdy=0 -> overflow=1 sticky, level stays 5.
  - Subsequent drain yields 0x11..0x15 only; 0x16 never appears.
- Full with out_rdy=1 and in_vld=1 on the same cycle -> pop and push both occur; level stays 5; no overflow.
- Stream 20 words 0x00..0x13 with push and pop every cycle and out_rdy held 1 -> exact in-order delivery across multiple pointer wraps.
  - Exactly 20 crd_rtn pulses; level never exceeds 1.
- Word 0xA5 arrives on edge 2 of INIT -> stored (level=1) but out_vld=0 until INIT completes.
  - First RUN cycle presents out_data=0xA5.
- Assert rst_n=0 mid-transfer with level=3 -> level, out_vld, crd_rtn are 0 immediately (async).
  - On release, 5 fresh crd_rtn pulses; old data is never emitted.
